line_window_3x3: RTL and testbench

LINE_WINDOW_3X3 -- requirements
Module: line_window_3x3

---
 rtl/line_window_3x3.sv | 111 +++++++++++
 tb/tb_line_window_3x3.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/line_window_3x3.sv
// 3x3 sliding-window generator for a raster pixel stream: two line buffers
// plus a column shift register, emitting only fully in-frame windows.
module line_window_3x3 #(
    parameter int IMG_W = 32,
    parameter int IMG_H = 32,
    parameter int PIX_W = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               conv_start,
    input  logic [PIX_W-1:0]   d_in,
    input  logic               d_valid,
    output logic [9*PIX_W-1:0] win_out,
    output logic               win_valid,
    output logic               frame_done
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic [CW-1:0]      col_q, col_d;
    logic [RW-1:0]      row_q, row_d;
    logic [PIX_W-1:0]   lb0_q [IMG_W];
    logic [PIX_W-1:0]   lb1_q [IMG_W];
    logic [PIX_W-1:0]   win_q [3][3];
    logic [PIX_W-1:0]   win_d [3][3];
    logic [9*PIX_W-1:0] win_out_q, win_out_d;
    logic               win_valid_q, win_valid_d;
    logic               frame_done_q, frame_done_d;
    logic               accept, col_last, row_last;

    assign accept   = conv_start & d_valid;
    assign col_last = (col_q == CW'(IMG_W - 1));
    assign row_last = (row_q == RW'(IMG_H - 1));

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (!conv_start) begin
            col_d = '0;
            row_d = '0;
        end else if (d_valid) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    // Each accepted pixel shifts the window left and brings in the column
    // (row r-2, row r-1, row r) read from the line buffers at this column.
    always_comb begin
        win_d = win_q;
        if (accept) begin
            for (int i = 0; i < 3; i++) begin
                win_d[i][0] = win_q[i][1];
                win_d[i][1] = win_q[i][2];
            end
            win_d[0][2] = lb1_q[col_q];
            win_d[1][2] = lb0_q[col_q];
            win_d[2][2] = d_in;
        end
    end

    // Gating on r>=2 and c>=2 keeps stale buffer contents and row-wrap
    // columns out of any window marked valid.
    always_comb begin
        win_valid_d  = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));
        frame_done_d = win_valid_d && col_last && row_last;
        win_out_d    = win_out_q;
        if (win_valid_d) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    win_out_d[PIX_W*(3*i+j) +: PIX_W] = win_d[i][j];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q        <= '0;
            row_q        <= '0;
            win_out_q    <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            win_out_q    <= win_out_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Pixel storage carries no reset; validity gating makes its contents moot.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1_q[col_q] <= lb0_q[col_q];
            lb0_q[col_q] <= d_in;
            win_q        <= win_d;
        end
    end

    assign win_out    = win_out_q;
    assign win_valid  = win_valid_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_line_window_3x3.sv
// Directed bench for line_window_3x3 on a 4x4 image whose pixel p = 4*r+c.
module tb_line_window_3x3;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int PW = 24;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          conv_start = 1'b0;
    logic [PW-1:0] d_in = '0;
    logic          d_valid = 1'b0;
    logic [9*PW-1:0] win_out;
    logic          win_valid;
    logic          frame_done;

    int vec  = 0;
    int miss = 0;
    int nwin = 0;
    int nfd  = 0;
    logic [9*PW-1:0] last_exp = '0;

    line_window_3x3 #(.IMG_W(W), .IMG_H(H), .PIX_W(PW)) dut (
        .clk(clk), .rst(rst), .conv_start(conv_start), .d_in(d_in),
        .d_valid(d_valid), .win_out(win_out), .win_valid(win_valid),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] pix(input int p);
        return {8'(p), 8'(p + 64), 8'(255 - p)};
    endfunction

    function automatic logic [9*PW-1:0] exp_win(input int r, input int c);
        logic [9*PW-1:0] w;
        w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[PW*(3*i+j) +: PW] = pix(W*(r-2+i) + (c-2+j));
        return w;
    endfunction

    task automatic chk(input string tag, input logic [9*PW-1:0] obs, input logic [9*PW-1:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One accepted pixel, then check the registered outputs it produced.
    task automatic send_pix(input int p);
        int r, c;
        logic v;
        r = p / W;
        c = p % W;
        v = (r >= 2) && (c >= 2);
        conv_start = 1'b1;
        d_valid    = 1'b1;
        d_in       = pix(p);
        @(posedge clk); #1;
        if (v) last_exp = exp_win(r, c);
        chk($sformatf("valid_p%0d", p), {215'd0, win_valid}, {215'd0, v});
        chk($sformatf("fdone_p%0d", p), {215'd0, frame_done}, {215'd0, (p == W*H-1)});
        chk($sformatf("win_p%0d", p), win_out, last_exp);
        if (win_valid) nwin++;
        if (frame_done) nfd++;
    endtask

    // A cycle with no accepted pixel: outputs quiet, window held.
    task automatic idle(input logic cs, input logic dv, input int p);
        conv_start = cs;
        d_valid    = dv;
        d_in       = pix(p);
        @(posedge clk); #1;
        chk("idle_valid", {215'd0, win_valid}, '0);
        chk("idle_fdone", {215'd0, frame_done}, '0);
        chk("idle_hold", win_out, last_exp);
    endtask

    task automatic send_frame(input bit gaps);
        for (int p = 0; p < W*H; p++) begin
            send_pix(p);
            if (gaps) idle(1'b1, 1'b0, 99);
        end
    endtask

    task automatic chk_counts(input string tag, input int ew, input int ef);
        chk({tag, "_nwin"}, 216'(nwin), 216'(ew));
        chk({tag, "_nfd"}, 216'(nfd), 216'(ef));
        nwin = 0;
        nfd  = 0;
    endtask

    initial begin
        int first_px [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
        logic [9*PW-1:0] first_w;
        first_w = '0;
        for (int k = 0; k < 9; k++) first_w[PW*k +: PW] = pix(first_px[k]);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {215'd0, win_valid}, '0);
        chk("rst_fdone", {215'd0, frame_done}, '0);
        chk("rst_win", win_out, '0);
        rst = 1'b1;
        idle(1'b1, 1'b0, 0);

        // Continuous frame
        send_frame(1'b0);
        chk_counts("cont", 4, 1);

        // Gapped frame, then first window checked against literal slot list
        for (int p = 0; p < W*H; p++) begin
            send_pix(p);
            if (p == 10) chk("gap_first_win", win_out, first_w);
            idle(1'b1, 1'b0, 77);
        end
        chk_counts("gap", 4, 1);

        // Two frames back to back
        send_frame(1'b0);
        send_frame(1'b0);
        chk_counts("b2b", 8, 2);

        // Asynchronous reset mid-frame after pixel 9
        for (int p = 0; p <= 9; p++) send_pix(p);
        rst = 1'b0;
        #1;
        last_exp = '0;
        chk("mid_rst_win", win_out, '0);
        chk("mid_rst_valid", {215'd0, win_valid}, '0);
        idle(1'b1, 1'b1, 10);
        idle(1'b1, 1'b1, 11);
        rst = 1'b1;
        nwin = 0;
        nfd  = 0;
        send_frame(1'b0);
        chk_counts("after_rst", 4, 1);

        // Abort after pixel 12: remaining pixels offered with conv_start low
        for (int p = 0; p <= 12; p++) send_pix(p);
        idle(1'b0, 1'b1, 13);
        idle(1'b0, 1'b1, 14);
        idle(1'b0, 1'b1, 15);
        chk_counts("aborted", 2, 0);
        send_frame(1'b0);
        chk_counts("after_abort", 4, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
